// File: rtl/sram_bank_arbiter.sv
// Per-bank round-robin arbiter sharing eight single-port SRAM banks between three requesters.
// Define ARB_R0_PRIO_EN to give R0 fixed top priority; R1/R2 then round-robin among themselves.
module sram_bank_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [8:0]            req_bank,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [3*DATA_W-1:0]   rdata,
  output logic [7:0]            cs,
  output logic [7:0]            we,
  output logic [8*ADDR_W-1:0]   addr,
  output logic [8*DATA_W-1:0]   wdata,
  input  logic [8*DATA_W-1:0]   read_data,
  output logic [15:0]           conflict_cnt
);

  localparam int NR = 3;
  localparam int NB = 8;

  logic [NB-1:0][1:0]        last_q, last_d;
  logic [NB-1:0]             cs_q, cs_d;
  logic [NB-1:0]             we_q, we_d;
  logic [NB-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0][DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]             own1_v_q, own1_v_d;
  logic [NB-1:0][1:0]        own1_id_q, own1_id_d;
  logic [NB-1:0]             own2_v_q, own2_v_d;
  logic [NB-1:0][1:0]        own2_id_q, own2_id_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [NR-1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [NB-1:0][NR-1:0]     cand;
  logic [NB-1:0][NR-1:0]     bank_gnt;
  logic [2:0]                gnt_c;
  logic [3:0]                denied;
  logic [16:0]               cnt_sum;
  logic [2:0]                rv_c;

  // Choose at most one winner from the candidate set given the bank's last-grant pointer.
  function automatic logic [2:0] rr_pick(input logic [2:0] c, input logic [1:0] last);
    logic [2:0] pick;
    pick = 3'b000;
`ifdef ARB_R0_PRIO_EN
    if (c[0]) begin
      pick = 3'b001;
    end else if (last == 2'd1) begin
      if (c[2])      pick = 3'b100;
      else if (c[1]) pick = 3'b010;
    end else begin
      if (c[1])      pick = 3'b010;
      else if (c[2]) pick = 3'b100;
    end
`else
    for (int i = 1; i <= 3; i++) begin
      int idx;
      idx = (int'(last) + i) % 3;
      if (pick == 3'b000 && c[idx]) pick[idx] = 1'b1;
    end
`endif
    return pick;
  endfunction

  function automatic logic [1:0] next_last(input logic [2:0] pick, input logic [1:0] last);
    logic [1:0] nl;
    nl = last;
`ifndef ARB_R0_PRIO_EN
    if (pick[0]) nl = 2'd0;
`endif
    if (pick[1]) nl = 2'd1;
    if (pick[2]) nl = 2'd2;
    return nl;
  endfunction

  always_comb begin
    cand     = '0;
    bank_gnt = '0;
    gnt_c    = 3'b000;
    denied   = 4'd0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NR; k++) begin
        cand[b][k] = req[k] && !rst && (req_bank[3*k +: 3] == 3'(b));
      end
      bank_gnt[b] = rr_pick(cand[b], last_q[b]);
      gnt_c       = gnt_c | bank_gnt[b];
      denied      = denied + 4'(cand[b][0]) + 4'(cand[b][1]) + 4'(cand[b][2])
                    - 4'(|cand[b]);
    end
  end

  assign gnt = gnt_c;

  // Command registers, owner pipeline and pointer updates.
  always_comb begin
    last_d    = last_q;
    cs_d      = '0;
    we_d      = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    own1_v_d  = '0;
    own1_id_d = '0;
    own2_v_d  = own1_v_q;
    own2_id_d = own1_id_q;
    for (int b = 0; b < NB; b++) begin
      last_d[b] = next_last(bank_gnt[b], last_q[b]);
      for (int k = 0; k < NR; k++) begin
        if (bank_gnt[b][k]) begin
          cs_d[b]      = 1'b1;
          we_d[b]      = req_we[k];
          addr_d[b]    = req_addr[k*ADDR_W +: ADDR_W];
          wdata_d[b]   = req_wdata[k*DATA_W +: DATA_W];
          own1_v_d[b]  = !req_we[k];
          own1_id_d[b] = 2'(k);
        end
      end
    end
    cnt_sum = {1'b0, cnt_q} + 17'(denied);
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Read return: each requester owns at most one bank slot in stage 2.
  always_comb begin
    rv_c    = 3'b000;
    rdata_d = rdata_q;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NR; k++) begin
        if (!rst && own2_v_q[b] && own2_id_q[b] == 2'(k)) begin
          rv_c[k]    = 1'b1;
          rdata_d[k] = read_data[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rvalid = rv_c;
  assign rdata  = rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= {NB{2'd2}};
      cs_q      <= '0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      own1_v_q  <= '0;
      own1_id_q <= '0;
      own2_v_q  <= '0;
      own2_id_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      last_q    <= last_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      own1_v_q  <= own1_v_d;
      own1_id_q <= own1_id_d;
      own2_v_q  <= own2_v_d;
      own2_id_q <= own2_id_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cs           = cs_q;
  assign we           = we_q;
  assign addr         = addr_q;
  assign wdata        = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter: reset, parallel writes, read latency, arbitration,
// mid-read reset and counter saturation, with a behavioural SRAM model behind the banks.
module tb_sram_bank_arbiter;
  localparam int AW = 10;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req, req_we;
  logic [8:0]      req_bank;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      gnt, rvalid;
  logic [3*DW-1:0] rdata;
  logic [7:0]      cs, we;
  logic [8*AW-1:0] addr;
  logic [8*DW-1:0] wdata;
  logic [8*DW-1:0] read_data;
  logic [15:0]     conflict_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [8][1024];
  logic [2:0]    exp_q[$];
  logic [2:0]    rr_exp [6];
  logic [2:0]    pair_exp [4];

  always #5 clk = ~clk;

  sram_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_bank(req_bank),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .read_data(read_data), .conflict_cnt(conflict_cnt)
  );

  // Single-port SRAM banks: read data valid the cycle after a read cs.
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (cs[b]) begin
        if (we[b]) mem[b][addr[b*AW +: AW]] <= wdata[b*DW +: DW];
        else       read_data[b*DW +: DW]     <= mem[b][addr[b*AW +: AW]];
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef ARB_R0_PRIO_EN
    rr_exp   = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    pair_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    rr_exp   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    pair_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
    rst = 1'b1; req = 3'b111; req_we = 3'b000; req_bank = '0;
    req_addr = '0; req_wdata = '0;

    // Reset held two cycles with all requests up
    next(); #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_cs", 64'(cs), 64'h0);
    check("rst_we", 64'(we), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_cnt", 64'(conflict_cnt), 64'h0);
    check("rst_rdata0", rdata[0 +: DW], 64'h0);
    next(); #1;
    check("rst_cs2", 64'(cs), 64'h0);
    check("rst_addr0", 64'(addr[0 +: AW]), 64'h0);

    // Parallel writes: R0 -> bank0 addr5, R1 -> bank3 addr7
    rst = 1'b0; req = 3'b011; req_we = 3'b011;
    req_bank = {3'd0, 3'd3, 3'd0};
    req_addr = {10'd0, 10'd7, 10'd5};
    req_wdata = {64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444};
    #1;
    check("pw_gnt", 64'(gnt), 64'h3);
    next();
    req = 3'b000; #1;
    check("pw_cs", 64'(cs), 64'h09);
    check("pw_we", 64'(we), 64'h09);
    check("pw_addr0", 64'(addr[0*AW +: AW]), 64'd5);
    check("pw_addr3", 64'(addr[3*AW +: AW]), 64'd7);
    check("pw_wdata0", wdata[0*DW +: DW], 64'h1111_2222_3333_4444);
    check("pw_wdata3", wdata[3*DW +: DW], 64'hAAAA_BBBB_CCCC_DDDD);
    check("pw_cnt", 64'(conflict_cnt), 64'h0);
    next();

    // R2 reads bank0 addr5: gnt in N, cs in N+1, rvalid in N+2
    req = 3'b100; req_we = 3'b000; req_bank = {3'd0, 3'd0, 3'd0};
    req_addr = {10'd5, 10'd0, 10'd0};
    #1;
    check("rd_gnt", 64'(gnt), 64'h4);
    next();
    req = 3'b000; #1;
    check("rd_cs", 64'(cs), 64'h01);
    check("rd_we", 64'(we), 64'h00);
    check("rd_addr0", 64'(addr[0*AW +: AW]), 64'd5);
    check("rd_addr3_hold", 64'(addr[3*AW +: AW]), 64'd7);
    check("rd_rvalid_n1", 64'(rvalid), 64'h0);
    next(); #1;
    check("rd_rvalid_n2", 64'(rvalid), 64'h4);
    check("rd_rdata2", rdata[2*DW +: DW], 64'h1111_2222_3333_4444);
    check("rd_rdata0_hold", rdata[0*DW +: DW], 64'h0);
    check("rd_rdata1_hold", rdata[1*DW +: DW], 64'h0);
    next(); #1;
    check("rd_rvalid_n3", 64'(rvalid), 64'h0);
    check("rd_rdata2_hold", rdata[2*DW +: DW], 64'h1111_2222_3333_4444);

    // Three-way contention on bank2 for six cycles
    req_bank = {3'd2, 3'd2, 3'd2};
    req_addr = {10'd3, 10'd2, 10'd1};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] g;
      req = (i < 6) ? 3'b111 : 3'b000;
      #1;
      g = (i < 6) ? rr_exp[i] : 3'b000;
      check($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(g));
      if (i >= 2) check($sformatf("rr_rvalid%0d", i), 64'(rvalid), 64'(exp_q.pop_front()));
      exp_q.push_back(g);
      if (i == 1) check("rr_cs", 64'(cs), 64'h04);
      if (i >= 6) check($sformatf("rr_cnt%0d", i), 64'(conflict_cnt), 64'd12);
      next();
    end
    exp_q.delete();

    // Two-way contention on bank1, then R0 drops
    req_bank = {3'd1, 3'd1, 3'd1};
    for (int i = 0; i < 4; i++) begin
      req = 3'b011; #1;
      check($sformatf("pair_gnt%0d", i), 64'(gnt), 64'(pair_exp[i]));
      next();
    end
    req = 3'b010; #1;
    check("pair_r1_alone", 64'(gnt), 64'h2);
    next();
    req = 3'b000; #1;
    check("pair_cnt", 64'(conflict_cnt), 64'd16);

    // Contention on bank4 in parallel with an uncontested bank5 grant
    req = 3'b111; req_bank = {3'd5, 3'd4, 3'd4}; #1;
    check("mix_gnt", 64'(gnt), 64'h5);
    next();
    req = 3'b000; #1;
    check("mix_cnt", 64'(conflict_cnt), 64'd17);
    check("mix_cs", 64'(cs), 64'h30);
    next();

    // Reset during an in-flight R1 read
    req = 3'b010; req_bank = {3'd0, 3'd0, 3'd0}; req_addr = {10'd0, 10'd5, 10'd0}; #1;
    check("mr_gnt", 64'(gnt), 64'h2);
    next();
    rst = 1'b1; req = 3'b111; req_bank = {3'd4, 3'd4, 3'd4}; #1;
    check("mr_gnt_in_rst", 64'(gnt), 64'h0);
    next();
    rst = 1'b0; req = 3'b000; #1;
    check("mr_rvalid_n2", 64'(rvalid), 64'h0);
    check("mr_cs", 64'(cs), 64'h0);
    check("mr_cnt", 64'(conflict_cnt), 64'h0);
    check("mr_rdata", rdata[1*DW +: DW], 64'h0);
    next(); #1;
    check("mr_rvalid_n3", 64'(rvalid), 64'h0);
    req = 3'b011; req_bank = {3'd4, 3'd4, 3'd4}; #1;
    check("mr_ptr_reset", 64'(gnt), 64'h1);
    next();

    // Saturation of the conflict counter
    req = 3'b111; req_bank = {3'd6, 3'd6, 3'd6};
    for (int j = 0; j < 32766; j++) next();
    #1;
    check("sat_fffd", 64'(conflict_cnt), 64'hFFFD);
    next(); #1;
    check("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
    next(); #1;
    check("sat_hold", 64'(conflict_cnt), 64'hFFFF);
    req = 3'b000;
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
